// File: rtl/ecc_apb_cmd_master.sv
`timescale 1ns/1ps
// APB command master for the ECC block; optional WAIT_DONE timeout under ECC_APB_MASTER_TIMEOUT_EN.
// Latency: push -> PSEL 1 cycle, rsp_valid 3 cycles without wait; 3 cycles per command back-to-back.
// Backpressure: cmd_ready drops while the command queue is full; responses cannot be stalled.

module ecc_apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdat,
  input  logic             pop,
  output logic [WIDTH-1:0] rdat,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdat;
  end

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign rdat = mem[rd_ptr];
endmodule

module ecc_apb_cmd_master #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int DONE_TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  input  logic                       cmd_wait_done,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic [DATA_WIDTH-1:0]      rsp_data_out,
  output logic [1:0]                 rsp_num_errors,
  output logic                       rsp_timeout,
  output logic                       busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                       write;
    logic [AMBA_ADDR_WIDTH-1:0] addr;
    logic [AMBA_WORD-1:0]       wdata;
    logic                       wait_done;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;

  state_t                     state, state_nxt;
  cmd_t                       cmd_in, head;
  logic [CW-1:0]              count;
  logic                       push, pop;
  logic                       cur_wait, cur_wait_nxt;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_nxt;
  logic [AMBA_WORD-1:0]       pwdata_nxt;
  logic                       pwrite_nxt, psel_nxt, penable_nxt;
  logic                       rsp_valid_nxt;
  logic [AMBA_WORD-1:0]       rsp_rdata_nxt;
  logic [DATA_WIDTH-1:0]      rsp_data_out_nxt;
  logic [1:0]                 rsp_num_errors_nxt;

`ifdef ECC_APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          rsp_timeout_nxt;
`else
  localparam int unused_done_timeout = DONE_TIMEOUT;
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, wait_done: cmd_wait_done};
  assign cmd_ready = !rst && (count < CW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = ((state == IDLE) || (state == RESP)) && (count != '0);
  assign busy      = (state != IDLE) || (count != '0);

  ecc_apb_cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdat  (cmd_in),
    .pop   (pop),
    .rdat  (head),
    .count (count)
  );

  always_comb begin
    state_nxt          = state;
    paddr_nxt          = PADDR;
    pwdata_nxt         = PWDATA;
    pwrite_nxt         = PWRITE;
    psel_nxt           = PSEL;
    penable_nxt        = PENABLE;
    cur_wait_nxt       = cur_wait;
    rsp_valid_nxt      = 1'b0;
    rsp_rdata_nxt      = rsp_rdata;
    rsp_data_out_nxt   = rsp_data_out;
    rsp_num_errors_nxt = rsp_num_errors;
`ifdef ECC_APB_MASTER_TIMEOUT_EN
    rsp_timeout_nxt    = rsp_timeout;
    to_cnt_nxt         = to_cnt;
`endif
    unique case (state)
      IDLE, RESP: begin
        if (pop) begin
          paddr_nxt    = head.addr;
          pwdata_nxt   = head.wdata;
          pwrite_nxt   = head.write;
          cur_wait_nxt = head.wait_done;
          psel_nxt     = 1'b1;
          penable_nxt  = 1'b0;
          state_nxt    = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        psel_nxt           = 1'b0;
        penable_nxt        = 1'b0;
        rsp_rdata_nxt      = PWRITE ? '0 : PRDATA;
        rsp_data_out_nxt   = '0;
        rsp_num_errors_nxt = '0;
`ifdef ECC_APB_MASTER_TIMEOUT_EN
        rsp_timeout_nxt    = 1'b0;
`endif
        if (!cur_wait || operation_done) begin
          if (cur_wait) begin
            rsp_data_out_nxt   = data_out;
            rsp_num_errors_nxt = num_of_errors;
          end
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else begin
          state_nxt = WAIT_DONE;
`ifdef ECC_APB_MASTER_TIMEOUT_EN
          to_cnt_nxt = '0;
`endif
        end
      end
      WAIT_DONE: begin
        if (operation_done) begin
          rsp_data_out_nxt   = data_out;
          rsp_num_errors_nxt = num_of_errors;
          rsp_valid_nxt      = 1'b1;
          state_nxt          = RESP;
        end
`ifdef ECC_APB_MASTER_TIMEOUT_EN
        // Counter value k means this is WAIT_DONE cycle k+1.
        else if (to_cnt == TW'(DONE_TIMEOUT - 1)) begin
          rsp_timeout_nxt = 1'b1;
          rsp_valid_nxt   = 1'b1;
          state_nxt       = RESP;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      PADDR          <= '0;
      PWDATA         <= '0;
      PWRITE         <= 1'b0;
      PSEL           <= 1'b0;
      PENABLE        <= 1'b0;
      cur_wait       <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_data_out   <= '0;
      rsp_num_errors <= '0;
`ifdef ECC_APB_MASTER_TIMEOUT_EN
      rsp_timeout    <= 1'b0;
      to_cnt         <= '0;
`endif
    end else begin
      state          <= state_nxt;
      PADDR          <= paddr_nxt;
      PWDATA         <= pwdata_nxt;
      PWRITE         <= pwrite_nxt;
      PSEL           <= psel_nxt;
      PENABLE        <= penable_nxt;
      cur_wait       <= cur_wait_nxt;
      rsp_valid      <= rsp_valid_nxt;
      rsp_rdata      <= rsp_rdata_nxt;
      rsp_data_out   <= rsp_data_out_nxt;
      rsp_num_errors <= rsp_num_errors_nxt;
`ifdef ECC_APB_MASTER_TIMEOUT_EN
      rsp_timeout    <= rsp_timeout_nxt;
      to_cnt         <= to_cnt_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_ecc_apb_cmd_master.sv
`timescale 1ns/1ps
// Scoreboard bench for ecc_apb_cmd_master: directed commands, queued expectations, negedge monitor.
module tb_ecc_apb_cmd_master;
  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_wait_done;
  logic [19:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [19:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        rsp_valid, rsp_timeout, busy;
  logic [31:0] rsp_rdata, rsp_data_out;
  logic [1:0]  rsp_num_errors;

  logic        prdata_auto;
  logic [31:0] prdata_reg;
  // Auto mode makes read data a function of the address so response order is visible.
  assign PRDATA = prdata_auto ? (32'h5A00_0000 | {12'h0, PADDR}) : prdata_reg;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] dout;
    logic [1:0]  nerr;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   rsp_cyc[$];
  int   tests = 0, fails = 0, cyc = 0, rsp_cnt = 0;

  ecc_apb_cmd_master #(.DONE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wait_done(cmd_wait_done),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRDATA(PRDATA), .operation_done(operation_done), .data_out(data_out),
    .num_of_errors(num_of_errors), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_data_out(rsp_data_out), .rsp_num_errors(rsp_num_errors),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [31:0] rd, input logic [31:0] dout,
                            input logic [1:0] nerr, input logic to);
    exp_t e;
    e.rdata = rd; e.dout = dout; e.nerr = nerr; e.to = to;
    sb.push_back(e);
  endtask

  // Leaves cmd_valid high so consecutive calls push without gaps.
  task automatic push(input logic w, input logic [19:0] a, input logic [31:0] d, input logic wt);
    int n;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wait_done = wt; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL push_wait: cmd_ready stuck at 0 for addr %0h", a);
    end else begin
      tick();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("drain_busy", busy, 0);
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      exp_t e;
      rsp_cnt++;
      rsp_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rsp: rdata %0h dout %0h with nothing expected", rsp_rdata, rsp_data_out);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_data_out", rsp_data_out, e.dout);
        chk("rsp_num_errors", rsp_num_errors, e.nerr);
        chk("rsp_timeout", rsp_timeout, e.to);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got %0d responses", rsp_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    int base, snap;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wait_done = 1'b0; operation_done = 1'b0; data_out = 32'h1111_1111;
    num_of_errors = 2'd3; prdata_auto = 1'b0; prdata_reg = 32'hFFFF_0000;

    // Reset state
    tick(); tick();
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    // Single write, no wait
    expect_rsp(32'h0, 32'h0, 2'd0, 1'b0);
    push(1'b1, 20'h4, 32'hA5A5_0001, 1'b0);
    cmd_valid = 1'b0;
    tick();
    chk("wr_t1_psel", PSEL, 1);
    chk("wr_t1_penable", PENABLE, 0);
    chk("wr_t1_paddr", PADDR, 20'h4);
    chk("wr_t1_pwrite", PWRITE, 1);
    chk("wr_t1_pwdata", PWDATA, 32'hA5A5_0001);
    tick();
    chk("wr_t2_psel", PSEL, 1);
    chk("wr_t2_penable", PENABLE, 1);
    tick();
    chk("wr_t3_rsp_valid", rsp_valid, 1);
    chk("wr_t3_psel", PSEL, 0);
    tick();
    chk("wr_t4_rsp_valid", rsp_valid, 0);
    chk("wr_t4_busy", busy, 0);

    // Read captures PRDATA during ACCESS only
    expect_rsp(32'h1234_5678, 32'h0, 2'd0, 1'b0);
    push(1'b0, 20'h8, 32'h0, 1'b0);
    cmd_valid = 1'b0;
    tick();
    chk("rd_pwrite", PWRITE, 0);
    chk("rd_paddr", PADDR, 20'h8);
    tick();
    prdata_reg = 32'h1234_5678;
    tick();
    prdata_reg = 32'hFFFF_0000;
    chk("rd_rsp_valid", rsp_valid, 1);
    tick();

    // Write that waits for operation_done
    expect_rsp(32'h0, 32'hDEAD_BEEF, 2'd1, 1'b0);
    push(1'b1, 20'hC, 32'h0000_0003, 1'b1);
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    chk("wait_no_rsp_access", rsp_valid, 0);
    chk("wait_psel_low", PSEL, 0);
    repeat (4) tick();
    chk("wait_no_rsp_before_done", rsp_valid, 0);
    operation_done = 1'b1; data_out = 32'hDEAD_BEEF; num_of_errors = 2'd1;
    tick();
    operation_done = 1'b0; data_out = 32'h1111_1111; num_of_errors = 2'd3;
    chk("wait_rsp_after_done", rsp_valid, 1);
    tick();
    chk("wait_rsp_one_cycle", rsp_valid, 0);

    // Queue full behind a stalled command, then back-to-back completion
    prdata_auto = 1'b1;
    base = rsp_cyc.size();
    expect_rsp(32'h0, 32'h0000_00AA, 2'd2, 1'b0);
    push(1'b1, 20'h10, 32'h1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      logic [19:0] a;
      a = 20'h100 + 20'(i * 4);
      expect_rsp((i % 2 == 1) ? 32'h0 : (32'h5A00_0000 | {12'h0, a}), 32'h0, 2'd0, 1'b0);
      push((i % 2 == 1), a, 32'(i), 1'b0);
    end
    chk("full_ready_low", cmd_ready, 0);
    expect_rsp(32'h0, 32'h0, 2'd0, 1'b0);
    cmd_write = 1'b1; cmd_addr = 20'h114; cmd_wdata = 32'd5; cmd_wait_done = 1'b0;
    tick();
    chk("full_ready_held", cmd_ready, 0);
    operation_done = 1'b1; data_out = 32'h0000_00AA; num_of_errors = 2'd2;
    tick();
    operation_done = 1'b0; data_out = 32'h1111_1111; num_of_errors = 2'd3;
    push(1'b1, 20'h114, 32'd5, 1'b0);
    cmd_valid = 1'b0;
    drain();
    chk("q_rsp_count", rsp_cyc.size(), base + 6);
    if (rsp_cyc.size() == base + 6) begin
      for (int i = 0; i < 5; i++)
        chk("q_rsp_spacing", rsp_cyc[base + i + 1] - rsp_cyc[base + i], 3);
    end

    // Reset during SETUP with two commands still queued
    expect_rsp(32'h0, 32'h0000_0077, 2'd0, 1'b0);
    push(1'b1, 20'h20, 32'h0, 1'b1);
    push(1'b0, 20'h24, 32'h0, 1'b0);
    push(1'b0, 20'h28, 32'h0, 1'b0);
    push(1'b0, 20'h2C, 32'h0, 1'b0);
    cmd_valid = 1'b0;
    operation_done = 1'b1; data_out = 32'h0000_0077; num_of_errors = 2'd0;
    tick();
    operation_done = 1'b0; data_out = 32'h1111_1111; num_of_errors = 2'd3;
    tick();
    chk("rstmid_setup_psel", PSEL, 1);
    chk("rstmid_setup_penable", PENABLE, 0);
    snap = rsp_cnt;
    rst = 1'b1;
    tick();
    chk("rstmid_psel", PSEL, 0);
    chk("rstmid_penable", PENABLE, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("rstmid_no_rsp", rsp_cnt, snap);
    chk("rstmid_busy_after", busy, 0);

`ifdef ECC_APB_MASTER_TIMEOUT_EN
    // Timeout after 8 WAIT_DONE cycles with no operation_done
    expect_rsp(32'h0, 32'h0, 2'd0, 1'b1);
    push(1'b1, 20'h30, 32'h0, 1'b1);
    cmd_valid = 1'b0;
    repeat (10) tick();
    chk("to_no_rsp_early", rsp_valid, 0);
    tick();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_flag", rsp_timeout, 1);
    tick();
`endif

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
